// File: rtl/sequenciador_parametrizado_pkg.sv
// Shared constants for the button-driven state sequencer.
//   MODO_*  : encodings of the 2-bit mode input
//   DIR_*   : ping-pong direction encodings
// Optional feature macro used by the sequencer: SEQ_DEBOUNCE_EN (see detector_borda_botao).
package sequenciador_parametrizado_pkg;

    typedef logic [1:0] modo_t;

    localparam modo_t MODO_CIRCULAR = 2'b00;
    localparam modo_t MODO_VAIVEM   = 2'b01;
    localparam modo_t MODO_SATURA   = 2'b10;
    localparam modo_t MODO_PARADO   = 2'b11;

    localparam logic DIR_SOBE  = 1'b0;
    localparam logic DIR_DESCE = 1'b1;

endpackage

// File: rtl/sequenciador_parametrizado_if.sv
// Button/mode inputs and state outputs of the sequencer, grouped as one bundle.
//   botao           : raw push-button (asynchronous to the clock)
//   modo            : 00 circular, 01 ping-pong, 10 saturating, 11 hold
//   estado_atual    : current state index
//   leds            : one-hot decode of estado_atual
//   direcao         : ping-pong direction (0 up, 1 down)
//   pulso_transicao : one-cycle pulse when the state has changed
// master = board/test side, slave = sequencer side.
interface sequenciador_parametrizado_if #(
    parameter int unsigned N_ESTADOS = 3
);
    localparam int unsigned W = $clog2(N_ESTADOS);

    logic                 botao;
    logic [1:0]           modo;
    logic [W-1:0]         estado_atual;
    logic [N_ESTADOS-1:0] leds;
    logic                 direcao;
    logic                 pulso_transicao;

    modport master (
        output botao,
        output modo,
        input  estado_atual,
        input  leds,
        input  direcao,
        input  pulso_transicao
    );

    modport slave (
        input  botao,
        input  modo,
        output estado_atual,
        output leds,
        output direcao,
        output pulso_transicao
    );
endinterface

// File: rtl/detector_borda_botao.sv
// Push-button front end: 2-flop synchroniser, optional debouncer, rising-edge detector.
//   clock       : rising-edge clock
//   reset       : asynchronous, active-high
//   botao       : raw button level
//   pulso_botao : one-cycle pulse per press (combinational from registered state)
// Macro SEQ_DEBOUNCE_EN: when defined, the synchronised level must be stable for
// DEBOUNCE_CICLOS consecutive samples before the filtered level follows it.
module detector_borda_botao #(
    parameter int unsigned DEBOUNCE_CICLOS = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic pulso_botao
);
    if (DEBOUNCE_CICLOS < 1) begin : g_erro_debounce
        $error("DEBOUNCE_CICLOS must be at least 1");
    end

    logic [1:0] sinc_q, sinc_d;
    // Marks which synchroniser stages hold a real sample rather than the reset value.
    logic [1:0] valido_q, valido_d;
    logic       anterior_q, anterior_d;
    // Edges are only accepted once a genuine low level has been seen, so a button
    // held across reset release does not produce a step.
    logic       armado_q, armado_d;
    logic       nivel;

`ifdef SEQ_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS + 1);
    logic [CW-1:0] cont_q, cont_d;
    logic          filtro_q, filtro_d;

    always_comb begin
        cont_d   = '0;
        filtro_d = filtro_q;
        if (sinc_q[1] != filtro_q) begin
            if (cont_q == CW'(DEBOUNCE_CICLOS - 1)) begin
                filtro_d = sinc_q[1];
            end else begin
                cont_d = cont_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont_q   <= '0;
            filtro_q <= 1'b0;
        end else begin
            cont_q   <= cont_d;
            filtro_q <= filtro_d;
        end
    end

    assign nivel = filtro_q;
`else
    assign nivel = sinc_q[1];
`endif

    always_comb begin
        sinc_d      = {sinc_q[0], botao};
        valido_d    = {valido_q[0], 1'b1};
        anterior_d  = nivel;
        armado_d    = armado_q | (valido_q[1] & ~sinc_q[1]);
        pulso_botao = armado_q & nivel & ~anterior_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc_q     <= '0;
            valido_q   <= '0;
            anterior_q <= 1'b0;
            armado_q   <= 1'b0;
        end else begin
            sinc_q     <= sinc_d;
            valido_q   <= valido_d;
            anterior_q <= anterior_d;
            armado_q   <= armado_d;
        end
    end
endmodule

// File: rtl/sequenciador_parametrizado.sv
// Button-driven state sequencer: steps through N_ESTADOS states on each press,
// in circular, ping-pong or saturating mode (or holds).
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave side of sequenciador_parametrizado_if (botao, modo in;
//           estado_atual, leds, direcao, pulso_transicao out)
// Macro SEQ_DEBOUNCE_EN enables the debouncer inside detector_borda_botao.
module sequenciador_parametrizado
    import sequenciador_parametrizado_pkg::*;
#(
    parameter int unsigned N_ESTADOS       = 3,
    parameter int unsigned DEBOUNCE_CICLOS = 4
) (
    input logic                         clock,
    input logic                         reset,
    sequenciador_parametrizado_if.slave bus
);
    if ((N_ESTADOS < 3) || (N_ESTADOS > 16)) begin : g_erro_n_estados
        $error("N_ESTADOS must be in the range 3..16");
    end

    localparam int unsigned  W      = $clog2(N_ESTADOS);
    localparam logic [W-1:0] ZERO   = '0;
    localparam logic [W-1:0] UM     = W'(1);
    localparam logic [W-1:0] ULTIMO = W'(N_ESTADOS - 1);

    logic [W-1:0] estado_q, estado_d;
    logic         direcao_q, direcao_d;
    logic         pulso_q, pulso_d;
    logic         pulso_botao;

    detector_borda_botao #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_detector (
        .clock      (clock),
        .reset      (reset),
        .botao      (bus.botao),
        .pulso_botao(pulso_botao)
    );

    // Wrap and turn-around use explicit compares: N_ESTADOS need not be a power of 2.
    always_comb begin
        estado_d  = estado_q;
        direcao_d = direcao_q;
        if (pulso_botao) begin
            unique case (bus.modo)
                MODO_CIRCULAR: begin
                    direcao_d = DIR_SOBE;
                    estado_d  = (estado_q == ULTIMO) ? ZERO : estado_q + UM;
                end
                MODO_VAIVEM: begin
                    if ((direcao_q == DIR_SOBE) && (estado_q != ULTIMO)) begin
                        estado_d = estado_q + UM;
                    end else if (estado_q == ZERO) begin
                        estado_d = UM;  // unreachable (down at 0); recover upward
                    end else begin
                        estado_d = estado_q - UM;
                    end
                    // Top turns us down, state 1 turns us up; otherwise keep moving the same way.
                    if (estado_d == ULTIMO) begin
                        direcao_d = DIR_DESCE;
                    end else if (estado_d == UM) begin
                        direcao_d = DIR_SOBE;
                    end else begin
                        direcao_d = (estado_d < estado_q) ? DIR_DESCE : DIR_SOBE;
                    end
                end
                MODO_SATURA: begin
                    direcao_d = DIR_SOBE;
                    if (estado_q != ULTIMO) begin
                        estado_d = estado_q + UM;
                    end
                end
                MODO_PARADO: begin
                    direcao_d = DIR_SOBE;
                end
            endcase
        end
        pulso_d = (estado_d != estado_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= ZERO;
            direcao_q <= DIR_SOBE;
            pulso_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            direcao_q <= direcao_d;
            pulso_q   <= pulso_d;
        end
    end

    always_comb begin
        bus.estado_atual    = estado_q;
        bus.direcao         = direcao_q;
        bus.pulso_transicao = pulso_q;
        bus.leds            = {{(N_ESTADOS - 1){1'b0}}, 1'b1} << estado_q;
    end
endmodule
